// File: rtl/bus_master_port.sv
// Master-side serial bus port: arbitration, serial address/data out,
// ack wait with timeout, and serial read-data capture.
module bus_master_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic                  m_req,
    input  logic                  m_grant,
    output logic                  m_mode,
    output logic                  m_wdata,
    output logic                  m_wvalid,
    input  logic                  m_ack,
    input  logic                  m_rdata,
    input  logic                  m_rvalid
);
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, ACK_WAIT, WDATA, RDATA, DONE
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [TW-1:0]         wcnt, wcnt_n;
    logic                  wr_q, wr_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] wd_q, wd_n;
    logic [DATA_WIDTH-1:0] sh_q, sh_n;
    logic                  d_ready_n, d_done_n, d_err_n;
    logic [DATA_WIDTH-1:0] d_rdata_n;
    logic                  m_req_n, m_mode_n, m_wdata_n, m_wvalid_n;
    logic                  busy, grant_lost;

    assign busy = (state == ADDR) || (state == ACK_WAIT) ||
                  (state == WDATA) || (state == RDATA);
    assign grant_lost = busy && !m_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            wcnt     <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            sh_q     <= '0;
            d_ready  <= 1'b1;
            d_done   <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
            m_req    <= 1'b0;
            m_mode   <= 1'b0;
            m_wdata  <= 1'b0;
            m_wvalid <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wcnt     <= wcnt_n;
            wr_q     <= wr_n;
            addr_q   <= addr_n;
            wd_q     <= wd_n;
            sh_q     <= sh_n;
            d_ready  <= d_ready_n;
            d_done   <= d_done_n;
            d_err    <= d_err_n;
            d_rdata  <= d_rdata_n;
            m_req    <= m_req_n;
            m_mode   <= m_mode_n;
            m_wdata  <= m_wdata_n;
            m_wvalid <= m_wvalid_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (d_valid) state_n = REQ;
            REQ:      if (m_grant) state_n = ADDR;
            ADDR: begin
                if (grant_lost) state_n = DONE;
                else if (cnt == CW'(ADDR_WIDTH)) state_n = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (grant_lost) state_n = DONE;
                else if (m_ack) state_n = wr_q ? WDATA : RDATA;
                else if (wcnt == TW'(TIMEOUT - 1)) state_n = DONE;
            end
            WDATA: begin
                if (grant_lost) state_n = DONE;
                else if (cnt == CW'(DATA_WIDTH)) state_n = DONE;
            end
            RDATA: begin
                if (grant_lost) state_n = DONE;
                else if (m_rvalid && cnt == CW'(DATA_WIDTH - 1)) state_n = DONE;
            end
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered with the state.
    always_comb begin
        cnt_n      = cnt;
        wcnt_n     = wcnt;
        wr_n       = wr_q;
        addr_n     = addr_q;
        wd_n       = wd_q;
        sh_n       = sh_q;
        d_ready_n  = d_ready;
        d_done_n   = 1'b0;
        d_err_n    = d_err;
        d_rdata_n  = d_rdata;
        m_req_n    = m_req;
        m_mode_n   = m_mode;
        m_wdata_n  = m_wdata;
        m_wvalid_n = m_wvalid;
        unique case (state)
            IDLE: begin
                d_ready_n = 1'b1;
                if (d_valid) begin
                    wr_n      = d_wr;
                    addr_n    = d_addr;
                    wd_n      = d_wdata;
                    d_ready_n = 1'b0;
                    m_req_n   = 1'b1;
                    m_mode_n  = d_wr;
                end
            end
            REQ: begin
                if (m_grant) begin
                    m_wvalid_n = 1'b1;
                    m_wdata_n  = addr_q[0];
                    addr_n     = addr_q >> 1;
                    cnt_n      = CW'(1);
                end
            end
            ADDR: begin
                if (state_n == ADDR) begin
                    m_wdata_n = addr_q[0];
                    addr_n    = addr_q >> 1;
                    cnt_n     = cnt + CW'(1);
                end else begin
                    m_wvalid_n = 1'b0;
                    wcnt_n     = '0;
                end
            end
            ACK_WAIT: begin
                if (state_n == WDATA) begin
                    m_wvalid_n = 1'b1;
                    m_wdata_n  = wd_q[0];
                    wd_n       = wd_q >> 1;
                    cnt_n      = CW'(1);
                end else if (state_n == RDATA) begin
                    cnt_n = '0;
                    sh_n  = '0;
                end else if (state_n == ACK_WAIT) begin
                    wcnt_n = wcnt + TW'(1);
                end
            end
            WDATA: begin
                if (state_n == WDATA) begin
                    m_wdata_n = wd_q[0];
                    wd_n      = wd_q >> 1;
                    cnt_n     = cnt + CW'(1);
                end
            end
            RDATA: begin
                if (m_rvalid && m_grant) begin
                    sh_n  = {m_rdata, sh_q[DATA_WIDTH-1:1]};
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                d_ready_n = 1'b1;
                d_err_n   = 1'b0;
                d_rdata_n = '0;
            end
            default: ;
        endcase
        if (state_n == DONE && state != DONE) begin
            d_done_n   = 1'b1;
            d_err_n    = grant_lost || (state == ACK_WAIT);
            d_rdata_n  = (state == RDATA && !grant_lost) ? sh_n : '0;
            m_req_n    = 1'b0;
            m_mode_n   = 1'b0;
            m_wvalid_n = 1'b0;
            m_wdata_n  = 1'b0;
        end
    end
endmodule
